mux_n_skid: RTL and testbench

- Parametrised, registered N-way data selector with a valid/ready handshake on both sides.
- Successor to the fixed 4-input, 32-bit combinational selector, intended for the pipelined core: writeback-source and forwarding selects cross a stage boundary here.
- A two-entry skid buffer gives full throughput, with in_ready driven purely from flops.
- Out-of-range selects are flagged per beat rather than silently aliased.

---
 rtl/mux_n_skid.sv | 78 +++++++
 tb/tb_mux_n_skid.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_skid.sv
// Registered N-way data selector with valid/ready on both sides.
// A head register plus one skid entry keeps full throughput while in_ready stays a pure flop.
module mux_n_skid #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_IN  = 4,
  localparam int unsigned SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] data;
  } beat_t;

  beat_t in_beat_c;
  beat_t head_q;
  beat_t skid_q;
  logic  skid_valid;
  logic  accept_c;
  logic  emit_c;

  // Out-of-range selects produce a zero beat with err set instead of aliasing.
  always_comb begin
    in_beat_c      = '0;
    in_beat_c.err  = 1'b1;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (32'(sel) == k) begin
        in_beat_c.data = in_data[k*WIDTH +: WIDTH];
        in_beat_c.err  = 1'b0;
      end
    end
  end

  assign accept_c = in_valid && in_ready;
  assign emit_c   = out_valid && out_ready;

  // While the skid is full in_ready is low, so only the drain path can fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      skid_q     <= '0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (skid_valid) begin
      if (emit_c) begin
        head_q     <= skid_q;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end
    end else if (accept_c) begin
      if (!out_valid || emit_c) begin
        head_q    <= in_beat_c;
        out_valid <= 1'b1;
      end else begin
        skid_q     <= in_beat_c;
        skid_valid <= 1'b1;
        in_ready   <= 1'b0;
      end
    end else if (emit_c) begin
      out_valid <= 1'b0;
    end
  end

  assign out_data = head_q.data;
  assign out_err  = head_q.err;

endmodule

// File: tb/tb_mux_n_skid.sv
// Directed bench for mux_n_skid: 4-, 5- and 3-input instances sharing clock and reset,
// plus a random valid/ready run on the 3-input instance checked against a queue.
module tb_mux_n_skid;

  logic clk;
  logic rst_n;

  logic [127:0] d4;
  logic [1:0]   sel4;
  logic         iv4, ir4, ov4, or4, oe4;
  logic [31:0]  od4;

  logic [39:0]  d5;
  logic [2:0]   sel5;
  logic         iv5, ir5, ov5, or5, oe5;
  logic [7:0]   od5;

  logic [23:0]  d3;
  logic [1:0]   sel3;
  logic         iv3, ir3, ov3, or3, oe3;
  logic [7:0]   od3;

  int checks = 0;
  int errors = 0;

  mux_n_skid #(.WIDTH(32), .N_IN(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4), .sel(sel4), .in_valid(iv4), .in_ready(ir4),
    .out_data(od4), .out_err(oe4), .out_valid(ov4), .out_ready(or4));

  mux_n_skid #(.WIDTH(8), .N_IN(5)) u5 (
    .clk(clk), .rst_n(rst_n), .in_data(d5), .sel(sel5), .in_valid(iv5), .in_ready(ir5),
    .out_data(od5), .out_err(oe5), .out_valid(ov5), .out_ready(or5));

  mux_n_skid #(.WIDTH(8), .N_IN(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3), .sel(sel3), .in_valid(iv3), .in_ready(ir3),
    .out_data(od3), .out_err(oe3), .out_valid(ov3), .out_ready(or3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] q[$];
    logic [8:0] exp_beat;
    logic [8:0] prev_head;
    logic [7:0] ed;
    logic       stall_prev;
    int         beats_in;
    int         beats_out;
    int         cyc;

    rst_n = 1'b0;
    d4 = '0; sel4 = '0; iv4 = 1'b0; or4 = 1'b0;
    d5 = '0; sel5 = '0; iv5 = 1'b0; or5 = 1'b0;
    d3 = '0; sel3 = '0; iv3 = 1'b0; or3 = 1'b0;
    tick();
    tick();
    check("rst_valid", 64'(ov4), 64'(0));
    check("rst_ready", 64'(ir4), 64'(1));
    check("rst_data",  64'(od4), 64'(0));
    check("rst_err",   64'(oe4), 64'(0));
    rst_n = 1'b1;
    tick();

    // Single beat
    d4   = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    sel4 = 2'd2; iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    check("single_valid", 64'(ov4), 64'(1));
    check("single_data",  64'(od4), 64'(32'hCCCC_0002));
    check("single_err",   64'(oe4), 64'(0));
    tick();
    check("single_hold", 64'(od4), 64'(32'hCCCC_0002));
    or4 = 1'b1;
    tick();
    check("single_clear", 64'(ov4), 64'(0));
    check("single_keep",  64'(od4), 64'(32'hCCCC_0002));

    // Streaming, one beat per cycle
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) d4[k*32 +: 32] = {8'(i), 8'(k), 16'hBEEF};
      sel4 = 2'(i);
      iv4  = 1'b1;
      tick();
      check("stream_valid", 64'(ov4), 64'(1));
      check("stream_data",  64'(od4), 64'({8'(i), 8'(i % 4), 16'hBEEF}));
      check("stream_ready", 64'(ir4), 64'(1));
    end
    iv4 = 1'b0;
    tick();
    check("stream_end", 64'(ov4), 64'(0));

    // Backpressure: head, skid, then a held third beat
    d4  = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    or4 = 1'b0;
    iv4 = 1'b1; sel4 = 2'd0;
    tick();
    check("bp_ready1", 64'(ir4), 64'(1));
    sel4 = 2'd1;
    tick();
    check("bp_ready2", 64'(ir4), 64'(0));
    check("bp_head2",  64'(od4), 64'(32'hAAAA_0000));
    sel4 = 2'd3;
    tick();
    check("bp_ready3", 64'(ir4), 64'(0));
    check("bp_head3",  64'(od4), 64'(32'hAAAA_0000));
    or4 = 1'b1;
    tick();
    check("bp_out1",   64'(od4), 64'(32'hBBBB_0001));
    check("bp_ready4", 64'(ir4), 64'(1));
    tick();
    iv4 = 1'b0;
    check("bp_out2", 64'(od4), 64'(32'hDDDD_0003));
    check("bp_val2", 64'(ov4), 64'(1));
    tick();
    check("bp_drain", 64'(ov4), 64'(0));

    // Out-of-range select on the 5-input instance
    d5  = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    or5 = 1'b1; iv5 = 1'b1; sel5 = 3'd6;
    tick();
    check("oor_data", 64'(od5), 64'(8'h00));
    check("oor_err",  64'(oe5), 64'(1));
    sel5 = 3'd4;
    tick();
    check("in4_data", 64'(od5), 64'(8'h55));
    check("in4_err",  64'(oe5), 64'(0));
    sel5 = 3'd5;
    tick();
    check("oor5_err", 64'(oe5), 64'(1));
    iv5 = 1'b0;
    tick();
    check("oor_clear", 64'(ov5), 64'(0));

    // Async reset with two beats stored
    or4 = 1'b0; iv4 = 1'b1; sel4 = 2'd2;
    tick();
    tick();
    iv4 = 1'b0;
    check("ar_full", 64'(ir4), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(ov4), 64'(0));
    check("ar_ready", 64'(ir4), 64'(1));
    check("ar_data",  64'(od4), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    or4 = 1'b1;
    tick();
    tick();
    check("ar_stale", 64'(ov4), 64'(0));

    // Random valid/ready on the 3-input instance against a queue model
    beats_in = 0; beats_out = 0; cyc = 0; stall_prev = 1'b0; prev_head = '0;
    while (beats_out < 300 && cyc < 5000) begin
      cyc++;
      if (stall_prev) check("stable3", 64'({oe3, od3}), 64'(prev_head));
      iv3  = ($urandom_range(0, 3) != 0) && (beats_in < 300);
      sel3 = 2'($urandom_range(0, 3));
      d3   = 24'($urandom());
      or3  = ($urandom_range(0, 2) != 0);
      if (ov3 && or3) begin
        if (q.size() == 0) begin
          check("spurious3", 64'(1), 64'(0));
        end else begin
          exp_beat = q.pop_front();
          check("order3", 64'({oe3, od3}), 64'(exp_beat));
        end
        beats_out++;
      end
      if (iv3 && ir3) begin
        ed = (sel3 < 2'd3) ? d3[32'(sel3)*8 +: 8] : 8'h00;
        q.push_back({(sel3 == 2'd3), ed});
        beats_in++;
      end
      stall_prev = ov3 && !or3;
      prev_head  = {oe3, od3};
      tick();
    end
    check("beats3", 64'(beats_out), 64'(300));
    check("drain3", 64'(q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
